// File: rtl/icmp_server_hls_deadlock_report_unit_if.sv
// Report channel of the deadlock report unit: one 40-bit word per deadlock event,
// transferred on a valid/ready handshake.
interface icmp_server_hls_deadlock_report_unit_if;
  logic        report_valid;
  logic        report_ready;
  logic [39:0] report_data;

  modport master (
    output report_valid,
    output report_data,
    input  report_ready
  );

  modport slave (
    input  report_valid,
    input  report_data,
    output report_ready
  );
endinterface

// File: rtl/icmp_server_hls_deadlock_report_unit.sv
// Deadlock collector: qualifies a sustained monitor block against TIMEOUT, latches the first
// offender and emits one report word. Optional macro: ICMP_DEADLOCK_REPORT_TIMESTAMP_EN.
module icmp_server_hls_deadlock_report_unit #(
  parameter int unsigned NUM_MON = 2,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_MON-1:0]  mon_block,
  input  logic                clear,
  output logic                deadlock,
  output logic [3:0]          deadlock_id,
  output logic [CNT_W-1:0]    blocked_cycles,
  icmp_server_hls_deadlock_report_unit_if.master report
);

  typedef enum logic [2:0] {StIdle, StWatch, StFired, StReport, StHold} state_e;

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] Timeout = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deadlock_q, deadlock_d;
  logic [3:0]       id_q, id_d;
  logic             valid_q, valid_d;
  logic [39:0]      data_q, data_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      stamp;
  logic [3:0]       low_idx;
  logic             any_block;

  function automatic logic [3:0] lowest_idx(logic [NUM_MON-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = int'(NUM_MON) - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  assign any_block = |mon_block;
  assign low_idx   = lowest_idx(mon_block);
  assign cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef ICMP_DEADLOCK_REPORT_TIMESTAMP_EN
  // Free-running; deliberately untouched by clear so reports stay comparable across re-arms.
  logic [31:0] ts_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
    end
  end

  assign stamp = ts_q;
`else
  assign stamp = 32'(cnt_q);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    deadlock_d = deadlock_q;
    id_d       = id_q;
    valid_d    = valid_q;
    data_d     = data_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (any_block) begin
          state_d = StWatch;
          cnt_d   = CNT_W'(1);
        end
      end
      StWatch: begin
        if (!any_block) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          // Offender and report word are latched on the edge that enters FIRED.
          if (cnt_q == Timeout) begin
            state_d    = StFired;
            deadlock_d = 1'b1;
            id_d       = low_idx;
            data_d     = {low_idx, 4'h0, stamp};
          end
        end
      end
      StFired: begin
        if (any_block) cnt_d = cnt_inc;
        state_d = StReport;
        valid_d = 1'b1;
      end
      StReport: begin
        if (any_block) cnt_d = cnt_inc;
        if (report.report_ready) begin
          state_d = StHold;
          valid_d = 1'b0;
        end
      end
      StHold: begin
        if (any_block) cnt_d = cnt_inc;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Clear overrides everything, including a same-cycle handshake or timeout.
    if (clear) begin
      state_d    = StIdle;
      cnt_d      = '0;
      deadlock_d = 1'b0;
      id_d       = '0;
      valid_d    = 1'b0;
      data_d     = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      deadlock_q <= 1'b0;
      id_q       <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      deadlock_q <= deadlock_d;
      id_q       <= id_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
    end
  end

  assign deadlock            = deadlock_q;
  assign deadlock_id         = id_q;
  assign blocked_cycles      = cnt_q;
  assign report.report_valid = valid_q;
  assign report.report_data  = data_q;

endmodule

// File: tb/tb_icmp_server_hls_deadlock_report_unit.sv
// Bench: two unit instances (default and a small saturating one) checked every cycle against
// a run-length behavioural model, plus directed literal checks.
module tb_icmp_server_hls_deadlock_report_unit;

  localparam int NA = 2, TA = 1024, CA = 32;
  localparam int NB = 3, TB = 4,    CB = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n;
  logic [NA-1:0] mon_a;
  logic          clear_a, dl_a;
  logic [3:0]    id_a;
  logic [CA-1:0] bc_a;
  logic [NB-1:0] mon_b;
  logic          clear_b, dl_b;
  logic [3:0]    id_b;
  logic [CB-1:0] bc_b;

  icmp_server_hls_deadlock_report_unit_if rep_a ();
  icmp_server_hls_deadlock_report_unit_if rep_b ();

  icmp_server_hls_deadlock_report_unit #(.NUM_MON(NA), .TIMEOUT(TA), .CNT_W(CA)) dut_a (
    .clock(clock), .reset_n(reset_n), .mon_block(mon_a), .clear(clear_a),
    .deadlock(dl_a), .deadlock_id(id_a), .blocked_cycles(bc_a), .report(rep_a)
  );

  icmp_server_hls_deadlock_report_unit #(.NUM_MON(NB), .TIMEOUT(TB), .CNT_W(CB)) dut_b (
    .clock(clock), .reset_n(reset_n), .mon_block(mon_b), .clear(clear_b),
    .deadlock(dl_b), .deadlock_id(id_b), .blocked_cycles(bc_b), .report(rep_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model: run = consecutive blocked cycles; arm = report due on the next edge.
  typedef struct {
    bit        dl;
    bit [3:0]  id;
    longint    run;
    bit        valid;
    bit        arm;
    bit [39:0] data;
    int        xfers;
    longint    ts;
  } model_t;

  function automatic model_t mreset();
    model_t m;
    m.dl = 0; m.id = 0; m.run = 0; m.valid = 0; m.arm = 0; m.data = 0; m.xfers = 0; m.ts = 0;
    return m;
  endfunction

  function automatic model_t step(model_t m, int nmon, int tmo, int cw,
                                  bit [15:0] mon, bit clr, bit rdy);
    model_t    n = m;
    bit        any = 0;
    bit [3:0]  low = 0;
    longint    maxc;
    bit [31:0] stamp;
    for (int i = nmon - 1; i >= 0; i--) begin
      if (mon[i]) begin any = 1; low = 4'(i); end
    end
    n.ts = m.ts + 1;
    if (clr) begin
      n.dl = 0; n.id = 0; n.run = 0; n.valid = 0; n.arm = 0; n.data = 0;
      return n;
    end
    maxc = (64'd1 << cw) - 1;
    if (m.arm) begin
      n.valid = 1; n.arm = 0;
    end else if (m.valid && rdy) begin
      n.valid = 0; n.xfers = m.xfers + 1;
    end
    if (!m.dl && any && m.run == longint'(tmo)) begin
`ifdef ICMP_DEADLOCK_REPORT_TIMESTAMP_EN
      stamp = 32'(m.ts);
`else
      stamp = 32'(m.run);
`endif
      n.dl = 1; n.id = low; n.data = {low, 4'h0, stamp}; n.arm = 1;
    end
    if (any) n.run = (m.run + 1 > maxc) ? maxc : m.run + 1;
    else if (!m.dl) n.run = 0;
    return n;
  endfunction

  model_t ma, mb;
  int obs_a, obs_b;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ma <= mreset();
      mb <= mreset();
    end else begin
      ma <= step(ma, NA, TA, CA, 16'(mon_a), clear_a, rep_a.report_ready);
      mb <= step(mb, NB, TB, CB, 16'(mon_b), clear_b, rep_b.report_ready);
    end
  end

  // Inputs change 1 time unit after posedge, so at negedge they are those of the next edge.
  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      obs_a <= 0;
      obs_b <= 0;
    end else begin
      if (rep_a.report_valid && rep_a.report_ready && !clear_a) obs_a <= obs_a + 1;
      if (rep_b.report_valid && rep_b.report_ready && !clear_b) obs_b <= obs_b + 1;
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      check("a_deadlock", 64'(dl_a), 64'(ma.dl));
      check("a_id", 64'(id_a), 64'(ma.id));
      check("a_blocked", 64'(bc_a), 64'(ma.run));
      check("a_valid", 64'(rep_a.report_valid), 64'(ma.valid));
      check("a_data", 64'(rep_a.report_data), 64'(ma.data));
      check("b_deadlock", 64'(dl_b), 64'(mb.dl));
      check("b_id", 64'(id_b), 64'(mb.id));
      check("b_blocked", 64'(bc_b), 64'(mb.run));
      check("b_valid", 64'(rep_b.report_valid), 64'(mb.valid));
      check("b_data", 64'(rep_b.report_data), 64'(mb.data));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [39:0] saved;
    int          runlen;
    bit          blk;
    reset_n = 0;
    mon_a = 0; clear_a = 0; rep_a.report_ready = 0;
    mon_b = 0; clear_b = 0; rep_b.report_ready = 0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1;
    check("rst_deadlock", 64'(dl_a), 64'd0);
    check("rst_valid", 64'(rep_a.report_valid), 64'd0);
    check("rst_data", 64'(rep_a.report_data), 64'd0);
    check("rst_blocked", 64'(bc_a), 64'd0);

    // Timeout with monitor 1 blocked.
    mon_a = 2'b10;
    for (int k = 0; k <= 1025; k++) begin
      tick();
      if (k == 1022) begin
        check("to_bc1023", 64'(bc_a), 64'd1023);
        check("to_nodl", 64'(dl_a), 64'd0);
      end
      if (k == 1023) check("to_bc1024", 64'(bc_a), 64'd1024);
      if (k == 1024) begin
        check("to_dl", 64'(dl_a), 64'd1);
        check("to_id", 64'(id_a), 64'd1);
        check("to_novalid", 64'(rep_a.report_valid), 64'd0);
      end
      if (k == 1025) begin
        check("to_valid", 64'(rep_a.report_valid), 64'd1);
`ifndef ICMP_DEADLOCK_REPORT_TIMESTAMP_EN
        check("to_data", 64'(rep_a.report_data), 64'h10_0000_0400);
`endif
        saved = rep_a.report_data;
      end
    end

    // Backpressure: data must hold until accepted, then no second report.
    for (int k = 0; k < 50; k++) begin
      tick();
      check("bp_data_stable", 64'(rep_a.report_data), 64'(saved));
      check("bp_valid_held", 64'(rep_a.report_valid), 64'd1);
    end
    rep_a.report_ready = 1;
    tick();
    check("bp_valid_drop", 64'(rep_a.report_valid), 64'd0);
    repeat (20) tick();
    check("bp_no_second", 64'(rep_a.report_valid), 64'd0);
    check("bp_still_dl", 64'(dl_a), 64'd1);
    check("bp_xfers", 64'(obs_a), 64'd1);
    check("bp_model_xfers", 64'(ma.xfers), 64'd1);
    rep_a.report_ready = 0;

    // Glitch restart.
    clear_a = 1;
    tick();
    clear_a = 0;
    check("clr_dl", 64'(dl_a), 64'd0);
    check("clr_bc", 64'(bc_a), 64'd0);
    mon_a = 2'b01;
    repeat (1023) tick();
    check("gl_bc1023", 64'(bc_a), 64'd1023);
    mon_a = 2'b00;
    tick();
    check("gl_bc0", 64'(bc_a), 64'd0);
    mon_a = 2'b01;
    for (int j = 0; j <= 1024; j++) begin
      tick();
      if (j == 1023) begin
        check("gl_nodl", 64'(dl_a), 64'd0);
        check("gl_bc1024", 64'(bc_a), 64'd1024);
      end
      if (j == 1024) check("gl_dl", 64'(dl_a), 64'd1);
    end

    // Priority: both monitors blocked -> id 0; clear beats a same-cycle handshake.
    clear_a = 1;
    tick();
    clear_a = 0;
    mon_a = 2'b11;
    repeat (1026) tick();
    check("pr_id0", 64'(id_a), 64'd0);
    check("pr_valid", 64'(rep_a.report_valid), 64'd1);
    clear_a = 1;
    rep_a.report_ready = 1;
    tick();
    clear_a = 0;
    rep_a.report_ready = 0;
    mon_a = 2'b00;
    check("pr_dl0", 64'(dl_a), 64'd0);
    check("pr_id_0", 64'(id_a), 64'd0);
    check("pr_bc0", 64'(bc_a), 64'd0);
    check("pr_valid0", 64'(rep_a.report_valid), 64'd0);
    check("pr_data0", 64'(rep_a.report_data), 64'd0);
    tick();
    check("pr_no_xfer", 64'(obs_a), 64'd1);

    // Saturation on the small instance (4-bit counter, timeout 4).
    mon_b = 3'b100;
    repeat (40) tick();
    check("sat_bc", 64'(bc_b), 64'd15);
    check("sat_model_bc", 64'(mb.run), 64'd15);
    check("sat_dl", 64'(dl_b), 64'd1);
    check("sat_id", 64'(id_b), 64'd2);
    mon_b = 0;

    // Reset in the middle of a pending report.
    mon_a = 2'b10;
    repeat (1026) tick();
    check("rm_valid_before", 64'(rep_a.report_valid), 64'd1);
    #2 reset_n = 0;
    #1;
    check("rm_valid_async", 64'(rep_a.report_valid), 64'd0);
    check("rm_dl_async", 64'(dl_a), 64'd0);
    mon_a = 2'b00;
    @(posedge clock);
    #1 reset_n = 1;
    repeat (5) tick();
    check("rm_idle_dl", 64'(dl_a), 64'd0);
    check("rm_idle_bc", 64'(bc_a), 64'd0);
    check("rm_idle_valid", 64'(rep_a.report_valid), 64'd0);

    // Randomised traffic on the small instance.
    runlen = 0;
    blk = 0;
    for (int c = 0; c < 3000; c++) begin
      if (runlen == 0) begin
        blk = ($urandom_range(0, 1) == 1);
        runlen = $urandom_range(1, 12);
      end
      runlen--;
      mon_b = blk ? NB'($urandom_range(1, 7)) : '0;
      rep_b.report_ready = ($urandom_range(0, 1) == 1);
      clear_b = ($urandom_range(0, 40) == 0);
      tick();
    end
    mon_b = 0;
    clear_b = 0;
    rep_b.report_ready = 0;
    repeat (3) tick();
    check("b_xfers", 64'(obs_b), 64'(mb.xfers));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
